cuenta1_secuenciador: RTL and testbench
=======================================

Name: cuenta1_secuenciador

Overview:
Upstream/downstream controller for the 3-bit ones-counter datapath (Valor/start in, Cuenta/fin out). It accepts a wide word by valid/ready handshake, splits it into 3-bit chunks (LSB chunk first), and issues one start per chunk. On each fin it accumulates Cuenta and delivers the total ones count of the word with a one-cycle valid pulse. A watchdog aborts with an error flag if the counter never answers.

Parameters:
NCHUNK, 4, number of 3-bit chunks per word; word width is 3*NCHUNK.
TW, 6, width of the total accumulator; the sum wraps modulo 2^TW.
TIMEOUT, 16, maximum cycles spent in ESPERA per chunk before abort.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
dato_in  input  3*NCHUNK  word to count; sampled on acceptance.
valido_in  input  1  upstream word valid.
listo_out  output  1  ready; high only in REPOSO.
Valor  output  3  current chunk to the counter.
start  output  1  one-cycle start pulse to the counter.
Cuenta  input  4  counter result; read only when fin is accepted.
fin  input  1  counter done; may stay high after completion.
total  output  TW  accumulated ones count; held until the next ENTREGA.
total_valido  output  1  one-cycle pulse; total and error are valid.
error  output  1  set in the ENTREGA cycle that follows a timeout, else 0.
ocupado  output  1  high in every state except REPOSO.

Behaviour:
- Reset (reset=0, asynchronous): state=REPOSO; Valor=0, start=0, total=0, total_valido=0, error=0, ocupado=0; internal data, accumulator, index and watchdog all 0. Takes effect immediately, including mid-operation. Any in-flight word is discarded.
- REPOSO: listo_out=1. Accept when valido_in=1 and listo_out=1: latch dato_in, acc=0, idx=0, go to ARRANQUE.
- ARRANQUE (1 cycle): Valor=dato[3*idx+:3], start=1, watchdog=0, go to ESPERA.
- ESPERA:
  - Valor is held and start=0.
  - The first ESPERA cycle is a guard cycle and ignores fin, because a stale fin may still be high.
  - From the second cycle on, fin=1 is accepted: acc += zero-extended Cuenta, idx++.
  - After an accepted fin, go to ENTREGA if idx was NCHUNK-1, else go to ARRANQUE.
  - The watchdog increments every ESPERA cycle. If it reaches TIMEOUT with no fin accepted, set err_int=1 and go to ENTREGA with the partial acc.
  - fin and timeout in the same cycle: fin wins, and no error is set.
- ENTREGA (1 cycle): total<=acc, total_valido=1, error=err_int; clear err_int; go to REPOSO.
- Latency per word: 1 accept + NCHUNK*(1 + ESPERA cycles) + 1 ENTREGA. The minimum ESPERA length is 2 cycles.
- Values of Cuenta above 3 are not checked; they are added as-is.
- Inputs have no effect outside their sampling states. valido_in held high causes back-to-back acceptance, with no bubble beyond the REPOSO cycle.
- Encoding: 3-bit state register plus next-state logic, which is purely combinational. Outputs are decoded from state, except total and error, which are registered.

Decomposition:
- Shared package (or a `define header): state encodings REPOSO, ARRANQUE, ESPERA, ENTREGA, plus the CHUNK_W=3 constant.
- One natural sub-module, cuenta1_watchdog: counter with clear, enable and timeout-flag output, parameterised by TIMEOUT. The FSM and datapath stay in the top.

Test Plan:
- The bench uses a behavioural counter model that raises fin 5 cycles after start and holds it high until the next start.
- dato_in=12'hFFF -> Valor sequence 7,7,7,7 with four start pulses; total=12, error=0, one total_valido pulse.
- dato_in=12'b101_000_011_001 -> Valor sequence 1,3,0,5; total=5; listo_out low throughout and high again the cycle after total_valido.
- Model holds fin=1 permanently from before the word starts -> each chunk is accepted on the second ESPERA cycle, never the first; total is still correct.
- Model never raises fin on chunk 2 -> after 16 ESPERA cycles, total_valido=1, error=1, total=count of chunks 0-1; the next word completes with error=0.
- reset pulsed low during ESPERA of chunk 1 -> start=0, ocupado=0, listo_out=1 immediately; total=0, and no total_valido pulse occurs.
- Two words offered back-to-back with valido_in held high -> two total_valido pulses with the correct totals in order; the second word is accepted in the REPOSO cycle right after ENTREGA.

Source files
------------

// File: rtl/cuenta1_secuenciador_pkg.sv
// Shared definitions for the ones-count sequencer: controller states and
// datapath widths.
package cuenta1_secuenciador_pkg;

  localparam int CHUNK_W  = 3;
  localparam int CUENTA_W = 4;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ARRANQUE = 3'd1,
    ESPERA   = 3'd2,
    ENTREGA  = 3'd3
  } estado_t;

endpackage

// File: rtl/cuenta1_secuenciador_if.sv
// Word-side handshake of the sequencer: the word in by valid/ready, and the
// total/error result out with its one-cycle valid pulse.
interface cuenta1_secuenciador_if
  import cuenta1_secuenciador_pkg::*;
#(
  parameter int NCHUNK = 4,
  parameter int TW     = 6
);

  logic [CHUNK_W*NCHUNK-1:0] dato_in;
  logic                      valido_in;
  logic                      listo_out;
  logic [TW-1:0]             total;
  logic                      total_valido;
  logic                      error;

  modport master (
    output dato_in, valido_in,
    input  listo_out, total, total_valido, error
  );

  modport slave (
    input  dato_in, valido_in,
    output listo_out, total, total_valido, error
  );

endinterface

// File: rtl/cuenta1_watchdog.sv
// Per-chunk wait counter: cleared on each start, counts wait cycles, flags the
// first wait cycle and the cycle on which the count reaches TIMEOUT.
module cuenta1_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic primero,
  output logic vence
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of wait cycles already completed, so the cycle
  // whose increment would reach TIMEOUT is the expiring one.
  assign primero = (cnt == '0);
  assign vence   = en && (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/cuenta1_secuenciador.sv
// Sequencer for the 3-bit ones counter: splits an accepted word into chunks,
// starts the counter on each, accumulates Cuenta and reports the total.
module cuenta1_secuenciador
  import cuenta1_secuenciador_pkg::*;
#(
  parameter int NCHUNK  = 4,
  parameter int TW      = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cuenta1_secuenciador_if.slave bus,
  output logic [CHUNK_W-1:0]   Valor,
  output logic                 start,
  input  logic [CUENTA_W-1:0]  Cuenta,
  input  logic                 fin,
  output logic                 ocupado
);

  localparam int W  = CHUNK_W * NCHUNK;
  localparam int IW = $clog2(NCHUNK + 1);

  estado_t       estado, estado_sig;
  logic [W-1:0]  dato;
  logic [TW-1:0] acc;
  logic [TW-1:0] acc_sum;
  logic [TW-1:0] total_q;
  logic          err_int;
  logic [IW-1:0] idx;

  logic wd_clr, wd_en, wd_primero, wd_vence;
  logic aceptar, fin_ok, ultimo, abortar;

  cuenta1_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .primero (wd_primero),
    .vence   (wd_vence)
  );

  // The first wait cycle is a guard: fin may still be high from the previous chunk.
  assign aceptar = (estado == REPOSO) && bus.valido_in;
  assign fin_ok  = (estado == ESPERA) && !wd_primero && fin;
  assign ultimo  = (idx == IW'(NCHUNK - 1));
  assign abortar = (estado == ESPERA) && !fin_ok && wd_vence;
  assign acc_sum = acc + TW'(Cuenta);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      REPOSO: begin
        if (bus.valido_in) estado_sig = ARRANQUE;
      end
      ARRANQUE: begin
        estado_sig = ESPERA;
      end
      ESPERA: begin
        if (fin_ok) begin
          estado_sig = ultimo ? ENTREGA : ARRANQUE;
        end else if (wd_vence) begin
          estado_sig = ENTREGA;
        end
      end
      ENTREGA: begin
        estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dato    <= '0;
      acc     <= '0;
      idx     <= '0;
      total_q <= '0;
      err_int <= 1'b0;
    end else begin
      if (aceptar) begin
        dato <= bus.dato_in;
        acc  <= '0;
        idx  <= '0;
      end
      if (fin_ok) begin
        acc <= acc_sum;
        idx <= idx + IW'(1);
      end
      // Result is captured on the way into ENTREGA so it is valid with the pulse.
      if ((estado == ESPERA) && (estado_sig == ENTREGA)) begin
        total_q <= fin_ok ? acc_sum : acc;
      end
      err_int <= abortar;
    end
  end

  assign wd_clr           = (estado == ARRANQUE);
  assign wd_en            = (estado == ESPERA);
  assign start            = (estado == ARRANQUE);
  assign ocupado          = (estado != REPOSO);
  assign bus.listo_out    = (estado == REPOSO);
  assign bus.total_valido = (estado == ENTREGA);
  assign bus.total        = total_q;
  assign bus.error        = err_int;
  assign Valor            = ((estado == ARRANQUE) || (estado == ESPERA))
                            ? CHUNK_W'(dato >> (CHUNK_W * int'(idx)))
                            : '0;

endmodule

// File: tb/tb_cuenta1_secuenciador.sv
// Bench for cuenta1_secuenciador: behavioural ones counter, vector table plus
// reset and back-to-back sequences, scoreboard queues for Valor and results.
module tb_cuenta1_secuenciador;

  localparam int NCHUNK   = 4;
  localparam int TW       = 6;
  localparam int TIMEOUT  = 16;
  localparam int W        = 3 * NCHUNK;
  localparam int M_NORMAL = 0;
  localparam int M_HOLD   = 1;
  localparam int M_MUTE   = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] Valor;
  logic       start;
  logic [3:0] Cuenta;
  logic       fin;
  logic       ocupado;

  cuenta1_secuenciador_if #(.NCHUNK(NCHUNK), .TW(TW)) bus ();

  cuenta1_secuenciador #(.NCHUNK(NCHUNK), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .Valor   (Valor),
    .start   (start),
    .Cuenta  (Cuenta),
    .fin     (fin),
    .ocupado (ocupado)
  );

  always #5 clk = ~clk;

  // Counter model: fin rises 5 cycles after start and stays high until the next start.
  int         modo     = M_NORMAL;
  int         mute_idx = -1;
  logic       fin_r    = 1'b0;
  int         cnt      = 0;
  logic [2:0] val_lat  = '0;
  int         nstart   = 0;

  function automatic logic [3:0] pop3(input logic [2:0] v);
    return 4'(v[0]) + 4'(v[1]) + 4'(v[2]);
  endfunction

  assign fin    = (modo == M_HOLD) ? 1'b1 : fin_r;
  assign Cuenta = pop3(val_lat);

  always @(posedge clk) begin
    if (bus.listo_out) nstart <= 0;
    if (start) begin
      val_lat <= Valor;
      fin_r   <= 1'b0;
      cnt     <= (modo == M_MUTE && nstart == mute_idx) ? 0 : 5;
      nstart  <= nstart + 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) fin_r <= 1'b1;
    end
  end

  typedef struct {
    logic [W-1:0] dato;
    int           modo;
    int           mute;
    int           exp_total;
    int           exp_err;
    int           spacing;
  } vec_t;

  vec_t tabla [6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wstart = 0;
  int last_start = 0;
  int last_tv = 0;
  int tv_cnt = 0;
  int spacing = 0;
  int acc_cyc = 0;
  int vq[$];
  int rq_t[$];
  int rq_e[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    if (start) begin
      if (vq.size() == 0) begin
        chk("start_unexpected", 1, 0);
      end else begin
        e = vq.pop_front();
        chk("valor", int'(Valor), e);
      end
      if (spacing > 0 && wstart > 0) chk("start_spacing", cyc - last_start, spacing);
      last_start = cyc;
      wstart++;
    end
    if (bus.total_valido) begin
      tv_cnt++;
      last_tv = cyc;
      if (rq_t.size() == 0) begin
        chk("total_valido_unexpected", 1, 0);
      end else begin
        e = rq_t.pop_front();
        chk("total", int'(bus.total), e);
        e = rq_e.pop_front();
        chk("error", int'(bus.error), e);
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d, input int et, input int ee,
                      input int nch, input bit keep);
    int n = 0;
    bus.dato_in   = d;
    bus.valido_in = 1'b1;
    while (!bus.listo_out && n < 400) begin
      tick();
      n++;
    end
    chk("accept_ready", int'(bus.listo_out), 1);
    for (int k = 0; k < nch; k++) vq.push_back(int'(d[3*k +: 3]));
    rq_t.push_back(et);
    rq_e.push_back(ee);
    acc_cyc = cyc;
    wstart  = 0;
    tick();
    if (!keep) bus.valido_in = 1'b0;
  endtask

  task automatic wait_tv(output int lo_bad);
    int t0 = tv_cnt;
    int n = 0;
    lo_bad = 0;
    while (tv_cnt == t0 && n < 400) begin
      tick();
      n++;
      if (tv_cnt == t0 && bus.listo_out) lo_bad++;
    end
    chk("total_valido_seen", tv_cnt - t0, 1);
  endtask

  initial begin
    int lo_bad;
    int nch;
    int n;
    int tv0;

    tabla[0] = '{12'hFFF, M_NORMAL, -1, 12, 0, 7};
    tabla[1] = '{12'b101_000_011_001, M_NORMAL, -1, 5, 0, 7};
    tabla[2] = '{12'h5A3, M_HOLD, -1, 6, 0, 3};
    tabla[3] = '{12'h0FF, M_MUTE, 2, 6, 1, 7};
    tabla[4] = '{12'h000, M_NORMAL, -1, 0, 0, 7};
    tabla[5] = '{12'h0FF, M_NORMAL, -1, 8, 0, 7};

    bus.dato_in   = '0;
    bus.valido_in = 1'b0;
    tick();
    tick();
    chk("rst_listo", int'(bus.listo_out), 1);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_valor", int'(Valor), 0);
    chk("rst_total", int'(bus.total), 0);
    chk("rst_total_valido", int'(bus.total_valido), 0);
    chk("rst_error", int'(bus.error), 0);
    reset = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      modo     = tabla[i].modo;
      mute_idx = tabla[i].mute;
      spacing  = tabla[i].spacing;
      nch      = (tabla[i].modo == M_MUTE) ? tabla[i].mute + 1 : NCHUNK;
      send(tabla[i].dato, tabla[i].exp_total, tabla[i].exp_err, nch, 1'b0);
      wait_tv(lo_bad);
      chk("listo_low_while_busy", lo_bad, 0);
      if (tabla[i].modo == M_MUTE) chk("timeout_length", last_tv - last_start, TIMEOUT + 1);
      tick();
      chk("listo_after_entrega", int'(bus.listo_out), 1);
      chk("ocupado_after_entrega", int'(ocupado), 0);
    end

    // Asynchronous reset in the middle of chunk 1's wait.
    modo    = M_NORMAL;
    spacing = 7;
    send(12'hFFF, 12, 0, NCHUNK, 1'b0);
    n = 0;
    while (wstart < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_reach_chunk1", wstart, 2);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_start", int'(start), 0);
    chk("midrst_ocupado", int'(ocupado), 0);
    chk("midrst_listo", int'(bus.listo_out), 1);
    chk("midrst_total", int'(bus.total), 0);
    chk("midrst_total_valido", int'(bus.total_valido), 0);
    chk("midrst_valor", int'(Valor), 0);
    vq.delete();
    rq_t.delete();
    rq_e.delete();
    tv0 = tv_cnt;
    #4 reset = 1'b1;
    repeat (40) tick();
    chk("midrst_no_pulse", tv_cnt - tv0, 0);

    // Two words with valido_in held high throughout.
    tv0 = tv_cnt;
    send(12'h111, 3, 0, NCHUNK, 1'b1);
    bus.dato_in = 12'hE38;
    send(12'hE38, 6, 0, NCHUNK, 1'b0);
    chk("b2b_accept_gap", acc_cyc - last_tv, 1);
    wait_tv(lo_bad);
    chk("b2b_pulses", tv_cnt - tv0, 2);
    tick();
    chk("b2b_idle", int'(bus.listo_out), 1);
    chk("queues_drained", vq.size() + rq_t.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
